// File: rtl/slot_pkg.sv
// rtl/slot_pkg.sv - shared types, constants and paytable for the slot credit controller
// Purpose: symbol width, jackpot constants, controller state encoding and the
//          payout multiplier lookup used when a play settles.
// Ports:   none (package)
package slot_pkg;

  localparam int SYM_W = 3;
  localparam logic [SYM_W-1:0] JACKPOT_SYM = 3'd7;
  localparam int JACKPOT_MULT = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPIN,
    ST_SETTLE,
    ST_EVAL,
    ST_PAY
  } state_t;

  // Raw, unclamped award for a winning line of 'sym'; caller narrows and clamps.
  function automatic logic [31:0] paytable(input logic [SYM_W-1:0] sym,
                                           input logic [31:0]      bet);
    logic [31:0] mult;
    if (sym == JACKPOT_SYM) mult = 32'(JACKPOT_MULT);
    else                    mult = 32'(sym) + 32'd2;
    return bet * mult;
  endfunction

endpackage

// File: rtl/slot_credit_acc.sv
// rtl/slot_credit_acc.sv - saturating credit balance accumulator
// Purpose: holds the credit balance; sums coin, debit and payout in one step
//          and clamps the result to MAX_CREDIT.
// Ports:   clock, reset (sync, active-high)
//          coin     in  add COIN_VALUE this cycle
//          debit    in  subtract BET this cycle (caller guarantees balance >= BET)
//          pay_add  in  payout to add this cycle (0 when none)
//          credits  out current balance
module slot_credit_acc #(
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 255,
  parameter int BET        = 1,
  parameter int COIN_VALUE = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin,
  input  logic                debit,
  input  logic [CREDIT_W-1:0] pay_add,
  output logic [CREDIT_W-1:0] credits
);

  // Wide enough that balance + payout + coin never overflows before clamping.
  localparam int SW = CREDIT_W + 7;

  logic [SW-1:0] sum;

  // All same-cycle contributions are combined first, then saturated once.
  always_comb begin
    sum = SW'(credits) + SW'(pay_add);
    if (coin)  sum = sum + SW'(COIN_VALUE);
    if (debit) sum = sum - SW'(BET);
  end

  always_ff @(posedge clock) begin
    if (reset)                      credits <= '0;
    else if (sum > SW'(MAX_CREDIT)) credits <= CREDIT_W'(MAX_CREDIT);
    else                            credits <= sum[CREDIT_W-1:0];
  end

endmodule

// File: rtl/slot_credit_ctrl.sv
// rtl/slot_credit_ctrl.sv - player credit controller wrapped around slot_machine
// Purpose: debits the bet, runs the spin and settle windows, samples the
//          symbols and credits the payout; coins are accepted at any time.
// Ports:   clock, reset (sync, active-high)
//          coin, play_req          in  1-cycle front-panel pulses
//          symbol1..3, win         in  from slot_machine
//          spin_start              out to slot_machine.start
//          credits                 out current balance
//          busy                    out state != IDLE
//          payout, payout_valid    out settled amount and its apply pulse
//          play_reject             out play_req refused for lack of credit
//          win_mismatch            out win asserted with unequal symbols
module slot_credit_ctrl
  import slot_pkg::*;
#(
  parameter int CREDIT_W      = 8,
  parameter int MAX_CREDIT    = 255,
  parameter int BET           = 1,
  parameter int COIN_VALUE    = 5,
  parameter int SPIN_CYCLES   = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin,
  input  logic                play_req,
  input  logic [SYM_W-1:0]    symbol1,
  input  logic [SYM_W-1:0]    symbol2,
  input  logic [SYM_W-1:0]    symbol3,
  input  logic                win,
  output logic                spin_start,
  output logic [CREDIT_W-1:0] credits,
  output logic                busy,
  output logic [CREDIT_W-1:0] payout,
  output logic                payout_valid,
  output logic                play_reject,
  output logic                win_mismatch
);

  localparam int PH_MAX = (SPIN_CYCLES > SETTLE_CYCLES) ? SPIN_CYCLES : SETTLE_CYCLES;
  localparam int CW     = $clog2(PH_MAX) + 1;
  localparam int PW     = CREDIT_W + 5;

  state_t              state, state_next;
  logic [CW-1:0]       phase;
  logic                debit, reject;
  logic                sym_eq, award;
  logic [PW-1:0]       raw_pay;
  logic [CREDIT_W-1:0] pay_clamped, pay_amt, pay_add;

  assign busy    = (state != ST_IDLE);
  assign sym_eq  = (symbol1 == symbol2) && (symbol2 == symbol3);
  assign award   = win && sym_eq;
  assign raw_pay = PW'(paytable(symbol1, 32'(BET)));
  assign pay_clamped = (raw_pay > PW'(MAX_CREDIT)) ? CREDIT_W'(MAX_CREDIT)
                                                   : raw_pay[CREDIT_W-1:0];
  assign pay_add = (state == ST_PAY) ? pay_amt : '0;

  // Eligibility uses the pre-coin balance, so a coin arriving with play_req
  // cannot fund that same request.
  always_comb begin
    state_next = state;
    debit      = 1'b0;
    reject     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (play_req) begin
          if (credits >= CREDIT_W'(BET)) begin
            debit      = 1'b1;
            state_next = ST_SPIN;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_SPIN:   if (phase == CW'(SPIN_CYCLES - 1))   state_next = ST_SETTLE;
      ST_SETTLE: if (phase == CW'(SETTLE_CYCLES - 1)) state_next = ST_EVAL;
      ST_EVAL:   state_next = ST_PAY;
      ST_PAY:    state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      phase <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        phase <= '0;
      else if (state == ST_SPIN || state == ST_SETTLE)
        phase <= phase + CW'(1);
    end
  end

  // spin_start is registered from next state so it is high for exactly the
  // cycles the FSM spends in SPIN. payout/payout_valid land with the credit update.
  always_ff @(posedge clock) begin
    if (reset) begin
      spin_start   <= 1'b0;
      play_reject  <= 1'b0;
      win_mismatch <= 1'b0;
      payout_valid <= 1'b0;
      payout       <= '0;
      pay_amt      <= '0;
    end else begin
      spin_start   <= (state_next == ST_SPIN);
      play_reject  <= reject;
      win_mismatch <= (state == ST_EVAL) && win && !sym_eq;
      payout_valid <= (state == ST_PAY);
      if (state == ST_EVAL) pay_amt <= award ? pay_clamped : '0;
      if (state == ST_PAY)  payout  <= pay_amt;
    end
  end

  slot_credit_acc #(
    .CREDIT_W  (CREDIT_W),
    .MAX_CREDIT(MAX_CREDIT),
    .BET       (BET),
    .COIN_VALUE(COIN_VALUE)
  ) u_acc (
    .clock  (clock),
    .reset  (reset),
    .coin   (coin),
    .debit  (debit),
    .pay_add(pay_add),
    .credits(credits)
  );

endmodule

// File: tb/tb_slot_credit_ctrl.sv
// tb/tb_slot_credit_ctrl.sv - directed self-checking bench for slot_credit_ctrl
module tb_slot_credit_ctrl;

  logic       clock = 1'b0;
  logic       reset, coin, play_req, win;
  logic [2:0] symbol1, symbol2, symbol3;
  logic       spin_start, busy, payout_valid, play_reject, win_mismatch;
  logic [7:0] credits, payout;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clock = ~clock;

  slot_credit_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .coin        (coin),
    .play_req    (play_req),
    .symbol1     (symbol1),
    .symbol2     (symbol2),
    .symbol3     (symbol3),
    .win         (win),
    .spin_start  (spin_start),
    .credits     (credits),
    .busy        (busy),
    .payout      (payout),
    .payout_valid(payout_valid),
    .play_reject (play_reject),
    .win_mismatch(win_mismatch)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic coins(input int n);
    for (int i = 0; i < n; i++) begin
      coin = 1'b1;
      tick();
    end
    coin = 1'b0;
  endtask

  // One full play with fixed symbols; expected payout goes to the scoreboard
  // at play_req and is popped when payout_valid appears.
  task automatic play(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                      input logic w, input int exp_pay, input int exp_credit,
                      input int exp_mm, input bit coin_in_pay, input string tag);
    int start_credit;
    int spin_cnt;
    int mm_cnt;
    int pv_cnt;
    int lat;
    int exp_p;
    spin_cnt = 0; mm_cnt = 0; pv_cnt = 0; lat = -1;
    symbol1 = a; symbol2 = b; symbol3 = c; win = w;
    start_credit = int'(credits);
    exp_q.push_back(exp_pay);
    play_req = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 1) begin
        play_req = 1'b0;
        chk({tag, "_debit"}, int'(credits), start_credit - 1);
      end
      if (coin_in_pay) coin = (k == 36);
      if (spin_start)   spin_cnt++;
      if (win_mismatch) mm_cnt++;
      if (payout_valid) begin
        pv_cnt++;
        if (lat < 0) begin
          lat   = k;
          exp_p = exp_q.pop_front();
          chk({tag, "_payout"}, int'(payout), exp_p);
          chk({tag, "_credits"}, int'(credits), exp_credit);
        end
      end
    end
    coin = 1'b0;
    if (lat < 0 && exp_q.size() > 0) exp_q.delete(0);
    chk({tag, "_latency"}, lat, 37);
    chk({tag, "_spin_cycles"}, spin_cnt, 32);
    chk({tag, "_mismatch"}, mm_cnt, exp_mm);
    chk({tag, "_pv_pulses"}, pv_cnt, 1);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int guard;
    reset = 1'b1; coin = 1'b0; play_req = 1'b0; win = 1'b0;
    symbol1 = 3'd0; symbol2 = 3'd0; symbol3 = 3'd0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_credits", int'(credits), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_spin", int'(spin_start), 0);
    chk("reset_pv", int'(payout_valid), 0);
    chk("reset_payout", int'(payout), 0);

    // No credit: request is refused
    play_req = 1'b1; tick(); play_req = 1'b0;
    chk("rej_pulse", int'(play_reject), 1);
    chk("rej_busy", int'(busy), 0);
    chk("rej_spin", int'(spin_start), 0);
    tick();
    chk("rej_pulse_end", int'(play_reject), 0);
    chk("rej_spin_after", int'(spin_start), 0);

    // Two coins, then win on 5,5,5 (pays 7)
    coins(2);
    chk("coins_10", int'(credits), 10);
    play(3'd5, 3'd5, 3'd5, 1'b1, 7, 16, 0, 1'b0, "t555");

    // Jackpot near the ceiling saturates
    coins(47);
    chk("coins_251", int'(credits), 251);
    play(3'd7, 3'd7, 3'd7, 1'b1, 20, 255, 0, 1'b0, "t777");

    // win without equal symbols, then a plain loss
    play(3'd1, 3'd2, 3'd1, 1'b1, 0, 254, 1, 1'b0, "t121");
    play(3'd4, 3'd4, 3'd4, 1'b0, 0, 253, 0, 1'b0, "tloss");

    // Reset mid-SPIN aborts without refund
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst2_credits", int'(credits), 0);
    coins(2);
    play_req = 1'b1; tick(); play_req = 1'b0;
    chk("abort_spin_on", int'(spin_start), 1);
    chk("abort_debit", int'(credits), 9);
    repeat (10) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_credits", int'(credits), 0);
    chk("abort_spin_off", int'(spin_start), 0);
    chk("abort_busy", int'(busy), 0);
    tick();
    chk("abort_stays_idle", int'(spin_start), 0);

    // Coin alongside play_req with zero balance: pre-coin credits decide
    coin = 1'b1; play_req = 1'b1; tick(); coin = 1'b0; play_req = 1'b0;
    chk("coinplay_reject", int'(play_reject), 1);
    chk("coinplay_credits", int'(credits), 5);
    chk("coinplay_busy", int'(busy), 0);

    // Coin and debit on the same edge
    win = 1'b0;
    coin = 1'b1; play_req = 1'b1; tick(); coin = 1'b0; play_req = 1'b0;
    chk("coindebit_credits", int'(credits), 9);
    chk("coindebit_busy", int'(busy), 1);
    guard = 0;
    while (busy && guard < 60) begin
      tick();
      guard++;
    end
    chk("coindebit_done", int'(busy), 0);
    chk("coindebit_final", int'(credits), 9);

    // Coin in the PAY cycle: 9 - 1 + 5 + 5
    play(3'd3, 3'd3, 3'd3, 1'b1, 5, 18, 0, 1'b1, "tcoinpay");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
